// File: rtl/vdp1_cmd_sequencer_pkg.sv
// Shared definitions for the VDP1 command-list sequencer.
//
// Holds the command-table container type, the jump-mode encodings found in
// CMDCTRL.JP, the sequencer state encoding and the helper that resolves
// where the list goes after a table has been handled.
//
// CMDCTRL layout used here: bit 15 = END, bits 14:12 = JP, bits 3:0 = COMM.
// CMDLINK holds the target byte address divided by 8.

package vdp1_cmd_sequencer_pkg;

    localparam int CMD_WORDS_DEF = 15;
    localparam int VRAM_AW_DEF   = 18;

    // Jump modes (JP[1:0]); JP[2] turns any of them into a skip variant
    localparam logic [1:0] JP_NEXT     = 2'b00;
    localparam logic [1:0] JP_ASSIGN   = 2'b01;
    localparam logic [1:0] JP_CALL     = 2'b10;
    localparam logic [1:0] JP_RETURN   = 2'b11;
    localparam int         JP_SKIP_BIT = 2;

    // Bit positions inside CMDCTRL
    localparam int CTRL_END_BIT = 15;
    localparam int CTRL_JP_LSB  = 12;

    // A full 32-byte command table; slot n sits at bits [16n+15:16n]
    typedef logic [15:0][15:0] CMDTBL_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_F_CTRL = 3'd1,
        ST_F_LINK = 3'd2,
        ST_F_BODY = 3'd3,
        ST_ISSUE  = 3'd4,
        ST_NEXT   = 3'd5,
        ST_ENDED  = 3'd6
    } CmdSeqState_t;

    typedef struct packed {
        logic [13:0] idx;
        logic [13:0] ret;
        logic        retV;
    } CmdNext_t;

    // Resolves the next table index from the jump mode. Only one call level
    // exists: a nested call simply overwrites the saved return index, and a
    // return without a pending call falls through to the next table.
    function automatic CmdNext_t CmdNextIdx(
        input logic [13:0] cur,
        input logic [1:0]  jp,
        input logic [15:0] cmdLink,
        input logic [13:0] ret,
        input logic        retV
    );
        CmdNext_t r;
        r.idx  = cur + 14'd1;
        r.ret  = ret;
        r.retV = retV;
        case (jp)
            JP_ASSIGN: r.idx = cmdLink[15:2];
            JP_CALL: begin
                r.ret  = cur + 14'd1;
                r.retV = 1'b1;
                r.idx  = cmdLink[15:2];
            end
            JP_RETURN: begin
                if (retV) begin
                    r.idx  = ret;
                    r.retV = 1'b0;
                end
            end
            default: r.idx = cur + 14'd1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vdp1_cmd_sequencer.sv
// VDP1 command-list sequencer.
//
// Walks the command list in VRAM one 32-byte table at a time, assembles the
// table and hands it to the draw engine, then resolves the list jump.
//
// Ports:
//   CLK, RST      clock and synchronous active-high reset
//   START         one-cycle plot trigger, restarts the list at byte 0
//   VRAM_A/RD     word address and read request towards the VRAM arbiter
//   VRAM_DI/RDY   read data and one-cycle completion strobe
//   CMD/CMD_VALID assembled table and its valid flag (word 0x1E reads as 0)
//   CMD_ACK       draw engine has consumed CMD
//   CEF           command end flag
//   LOPR/COPR     last completed / current command byte address >> 3
//   BUSY          list walk in progress

module vdp1_cmd_sequencer
    import vdp1_cmd_sequencer_pkg::*;
#(
    parameter int CMD_WORDS = CMD_WORDS_DEF,
    parameter int VRAM_AW   = VRAM_AW_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    output logic [VRAM_AW-1:0] VRAM_A,
    output logic               VRAM_RD,
    input  logic [15:0]        VRAM_DI,
    input  logic               VRAM_RDY,
    output CMDTBL_t            CMD,
    output logic               CMD_VALID,
    input  logic               CMD_ACK,
    output logic               CEF,
    output logic [15:0]        LOPR,
    output logic [15:0]        COPR,
    output logic               BUSY
);

    localparam logic [3:0] LAST_WORD = 4'(CMD_WORDS - 1);

    CmdSeqState_t state_q, state_d;
    logic [13:0]  cur_q, cur_d;
    logic [13:0]  ret_q, ret_d;
    logic         retV_q, retV_d;
    logic [3:0]   word_q, word_d;
    logic         rd_q, rd_d;
    logic         valid_q, valid_d;
    logic         cef_q, cef_d;
    logic [15:0]  lopr_q, lopr_d;
    logic [CMD_WORDS-1:0][15:0] tbl_q, tbl_d;

    logic [15:0]  copr;
    CmdNext_t     nextIdx;

    assign copr = {cur_q, 2'b00};

    // Next-state logic. START outranks everything except reset, including a
    // read completion landing in the same cycle, so an aborted word is never
    // stored. A read is requested one cycle after its word is selected, which
    // also guarantees an idle cycle between back-to-back reads.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        ret_d   = ret_q;
        retV_d  = retV_q;
        word_d  = word_q;
        rd_d    = rd_q;
        valid_d = valid_q;
        cef_d   = cef_q;
        lopr_d  = lopr_q;
        tbl_d   = tbl_q;
        nextIdx = CmdNextIdx(cur_q, tbl_q[0][CTRL_JP_LSB +: 2], tbl_q[1], ret_q, retV_q);

        if (START) begin
            state_d = ST_F_CTRL;
            cur_d   = '0;
            retV_d  = 1'b0;
            word_d  = '0;
            rd_d    = 1'b0;
            valid_d = 1'b0;
            cef_d   = 1'b0;
        end else begin
            case (state_q)
                ST_F_CTRL, ST_F_LINK, ST_F_BODY: begin
                    if (!rd_q) begin
                        rd_d = 1'b1;
                    end else if (VRAM_RDY) begin
                        rd_d          = 1'b0;
                        tbl_d[word_q] = VRAM_DI;
                        word_d        = word_q + 4'd1;
                        if (state_q == ST_F_CTRL) begin
                            if (VRAM_DI[CTRL_END_BIT]) begin
                                cef_d   = 1'b1;
                                lopr_d  = copr;
                                state_d = ST_ENDED;
                            end else begin
                                state_d = ST_F_LINK;
                            end
                        end else if (state_q == ST_F_LINK) begin
                            if (tbl_q[0][CTRL_JP_LSB + JP_SKIP_BIT]) begin
                                state_d = ST_NEXT;
                            end else begin
                                state_d = ST_F_BODY;
                            end
                        end else if (word_q == LAST_WORD) begin
                            valid_d = 1'b1;
                            state_d = ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (CMD_ACK) begin
                        valid_d = 1'b0;
                        state_d = ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    lopr_d  = copr;
                    cur_d   = nextIdx.idx;
                    ret_d   = nextIdx.ret;
                    retV_d  = nextIdx.retV;
                    word_d  = '0;
                    state_d = ST_F_CTRL;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // State and datapath registers; reset returns everything to idle zero
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            ret_q   <= '0;
            retV_q  <= 1'b0;
            word_q  <= '0;
            rd_q    <= 1'b0;
            valid_q <= 1'b0;
            cef_q   <= 1'b0;
            lopr_q  <= '0;
            tbl_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            ret_q   <= ret_d;
            retV_q  <= retV_d;
            word_q  <= word_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
            cef_q   <= cef_d;
            lopr_q  <= lopr_d;
            tbl_q   <= tbl_d;
        end
    end

    // Word 0x1E is never fetched, so the top slot of CMD is zero-filled
    always_comb begin
        VRAM_A    = VRAM_AW'({cur_q, word_q});
        VRAM_RD   = rd_q;
        CMD       = 256'(tbl_q);
        CMD_VALID = valid_q;
        CEF       = cef_q;
        LOPR      = lopr_q;
        COPR      = copr;
        BUSY      = (state_q != ST_IDLE) && (state_q != ST_ENDED);
    end

endmodule

// File: tb/tb_vdp1_cmd_sequencer.sv
// Directed bench for the VDP1 command-list sequencer: a VRAM responder with
// programmable latency, an auto-acknowledging draw engine and a monitor that
// logs reads and issued tables for the linear sequence of checks below.

module tb_vdp1_cmd_sequencer;

    logic         CLK = 1'b0;
    logic         RST;
    logic         START;
    logic [17:0]  VRAM_A;
    logic         VRAM_RD;
    logic [15:0]  VRAM_DI;
    logic         VRAM_RDY;
    logic [255:0] CMD;
    logic         CMD_VALID;
    logic         CMD_ACK;
    logic         CEF;
    logic [15:0]  LOPR;
    logic [15:0]  COPR;
    logic         BUSY;

    vdp1_cmd_sequencer dut (
        .CLK(CLK), .RST(RST), .START(START),
        .VRAM_A(VRAM_A), .VRAM_RD(VRAM_RD), .VRAM_DI(VRAM_DI), .VRAM_RDY(VRAM_RDY),
        .CMD(CMD), .CMD_VALID(CMD_VALID), .CMD_ACK(CMD_ACK),
        .CEF(CEF), .LOPR(LOPR), .COPR(COPR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    logic [15:0] mem [0:262143];

    int checks = 0;
    int errors = 0;

    bit respEnable = 1'b1;
    bit randomDelay = 1'b0;
    int fixedDelay = 0;
    bit ackEnable = 1'b1;
    int ackDelay = 0;

    int readCount = 0;
    int issueCount = 0;
    int unstable = 0;
    int validCycles = 0;
    logic [17:0] readAddr[$];
    logic [15:0] readLopr[$];
    logic [15:0] issuedCopr[$];
    logic [15:0] issuedComm[$];
    logic [255:0] prevCmd = '0;
    logic prevValid = 1'b0;

    // VRAM responder: answers the outstanding read after a programmable delay
    initial begin : responder
        bit pend;
        int waitCnt;
        int curDelay;
        pend = 1'b0;
        waitCnt = 0;
        curDelay = 0;
        VRAM_RDY = 1'b0;
        VRAM_DI = '0;
        forever begin
            @(negedge CLK);
            if (!respEnable) begin
                pend = 1'b0;
            end else if (VRAM_RDY) begin
                VRAM_RDY = 1'b0;
            end else if (VRAM_RD !== 1'b1) begin
                pend = 1'b0;
            end else begin
                if (!pend) begin
                    pend = 1'b1;
                    waitCnt = 0;
                    curDelay = randomDelay ? int'($urandom_range(0, 7)) : fixedDelay;
                end
                if (waitCnt >= curDelay) begin
                    VRAM_DI = mem[VRAM_A];
                    VRAM_RDY = 1'b1;
                    pend = 1'b0;
                end else begin
                    waitCnt++;
                end
            end
        end
    end

    // Draw engine: acknowledges CMD_VALID after ackDelay idle cycles
    initial begin : acker
        int ackWait;
        ackWait = 0;
        CMD_ACK = 1'b0;
        forever begin
            @(negedge CLK);
            if (!ackEnable) begin
                ackWait = 0;
            end else if (CMD_ACK) begin
                CMD_ACK = 1'b0;
            end else if (CMD_VALID === 1'b1) begin
                if (ackWait >= ackDelay) begin
                    CMD_ACK = 1'b1;
                    ackWait = 0;
                end else begin
                    ackWait++;
                end
            end else begin
                ackWait = 0;
            end
        end
    end

    // Monitor: logs completed reads, handshakes and CMD stability
    always @(posedge CLK) begin
        if (VRAM_RD === 1'b1 && VRAM_RDY === 1'b1) begin
            readCount++;
            readAddr.push_back(VRAM_A);
            readLopr.push_back(LOPR);
        end
        if (CMD_VALID === 1'b1) validCycles++;
        if (CMD_VALID === 1'b1 && CMD_ACK === 1'b1) begin
            issueCount++;
            issuedCopr.push_back(COPR);
            issuedComm.push_back({12'h000, CMD[3:0]});
        end
        if (CMD_VALID === 1'b1 && prevValid === 1'b1 && CMD !== prevCmd) unstable++;
        prevValid = CMD_VALID;
        prevCmd = CMD;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One-cycle START pulse; returns on the negedge after it was sampled
    task automatic applyStimulus();
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic waitEnd(input string tag, input int budget);
        int n;
        n = 0;
        while (CEF !== 1'b1 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        checkOutput(tag, {31'd0, CEF}, 32'd1);
    endtask

    task automatic clearMem();
        foreach (mem[i]) mem[i] = 16'h0000;
    endtask

    task automatic writeTable(input int idx, input logic [15:0] ctrl, input logic [15:0] link,
                              input logic [15:0] fill);
        int base;
        base = idx * 16;
        mem[base] = ctrl;
        mem[base + 1] = link;
        for (int w = 2; w < 16; w++) mem[base + w] = fill + 16'(w);
    endtask

    function automatic logic [15:0] ctrlWord(input logic [2:0] jp, input logic [3:0] comm);
        return {1'b0, jp, 8'h00, comm};
    endfunction

    task automatic loadLinear();
        clearMem();
        writeTable(0, ctrlWord(3'b000, 4'h0), 16'h0000, 16'h1000);
        writeTable(1, ctrlWord(3'b000, 4'h4), 16'h0000, 16'h2000);
        writeTable(2, ctrlWord(3'b000, 4'hB), 16'h0000, 16'h3000);
        mem[3 * 16] = 16'h8000;
    endtask

    initial begin : mainSeq
        int rb;
        int ib;
        int rc;
        int ic;
        int vc;
        int n;
        RST = 1'b1;
        START = 1'b0;

        // Reset state
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        checkOutput("reset_busy", {31'd0, BUSY}, 32'd0);
        checkOutput("reset_valid", {31'd0, CMD_VALID}, 32'd0);
        checkOutput("reset_rd", {31'd0, VRAM_RD}, 32'd0);
        checkOutput("reset_cef", {31'd0, CEF}, 32'd0);
        checkOutput("reset_lopr", {16'd0, LOPR}, 32'd0);
        checkOutput("reset_copr", {16'd0, COPR}, 32'd0);
        checkOutput("reset_cmd_w0", {16'd0, CMD[15:0]}, 32'd0);
        checkOutput("reset_cmd_w14", {16'd0, CMD[239:224]}, 32'd0);

        // Linear list: three drawables then END at byte 0x60
        $display("[TB] linear list");
        loadLinear();
        fixedDelay = 1;
        ackDelay = 2;
        rb = readAddr.size();
        ib = issuedCopr.size();
        rc = readCount;
        ic = issueCount;
        applyStimulus();
        checkOutput("lin_busy_after_start", {31'd0, BUSY}, 32'd1);
        checkOutput("lin_rd_low_after_start", {31'd0, VRAM_RD}, 32'd0);
        waitEnd("lin_end_reached", 3000);
        checkOutput("lin_issues", issueCount - ic, 32'd3);
        checkOutput("lin_reads", readCount - rc, 32'd46);
        checkOutput("lin_copr0", {16'd0, issuedCopr[ib]}, 32'h0000);
        checkOutput("lin_copr1", {16'd0, issuedCopr[ib + 1]}, 32'h0004);
        checkOutput("lin_copr2", {16'd0, issuedCopr[ib + 2]}, 32'h0008);
        checkOutput("lin_comm2_unknown", {16'd0, issuedComm[ib + 2]}, 32'h000B);
        checkOutput("lin_first_addr", {14'd0, readAddr[rb]}, 32'h00000);
        checkOutput("lin_end_addr", {14'd0, readAddr[rb + 45]}, 32'h00030);
        checkOutput("lin_lopr_before_end", {16'd0, readLopr[rb + 45]}, 32'h0008);
        checkOutput("lin_lopr_final", {16'd0, LOPR}, 32'h000C);
        checkOutput("lin_busy_final", {31'd0, BUSY}, 32'd0);
        checkOutput("lin_cmd_w2", {16'd0, CMD[47:32]}, 32'h3002);
        checkOutput("lin_cmd_w1e_zero", {16'd0, CMD[255:240]}, 32'd0);

        // Assign: table 0 jumps to CMDLINK 0x0100 (byte 0x800)
        $display("[TB] assign");
        clearMem();
        writeTable(0, ctrlWord(3'b001, 4'h1), 16'h0100, 16'h4000);
        mem[16'h0400] = 16'h8000;
        rb = readAddr.size();
        ib = issuedCopr.size();
        rc = readCount;
        ic = issueCount;
        applyStimulus();
        waitEnd("asg_end_reached", 1000);
        checkOutput("asg_issues", issueCount - ic, 32'd1);
        checkOutput("asg_reads", readCount - rc, 32'd16);
        checkOutput("asg_second_addr", {14'd0, readAddr[rb + 15]}, 32'h00400);
        checkOutput("asg_copr", {16'd0, COPR}, 32'h0100);

        // Call to 0x0200, return to table 1, second return falls through
        $display("[TB] call/return");
        clearMem();
        writeTable(0, ctrlWord(3'b010, 4'h0), 16'h0200, 16'h5000);
        writeTable(16'h0080, ctrlWord(3'b011, 4'h1), 16'h0000, 16'h6000);
        writeTable(1, ctrlWord(3'b011, 4'h2), 16'h0400, 16'h7000);
        mem[2 * 16] = 16'h8000;
        rb = readAddr.size();
        ib = issuedCopr.size();
        rc = readCount;
        ic = issueCount;
        applyStimulus();
        waitEnd("call_end_reached", 3000);
        checkOutput("call_issues", issueCount - ic, 32'd3);
        checkOutput("call_reads", readCount - rc, 32'd46);
        checkOutput("call_copr1", {16'd0, issuedCopr[ib + 1]}, 32'h0200);
        checkOutput("call_copr2_return", {16'd0, issuedCopr[ib + 2]}, 32'h0004);
        checkOutput("call_target_addr", {14'd0, readAddr[rb + 15]}, 32'h00800);
        checkOutput("call_return_addr", {14'd0, readAddr[rb + 30]}, 32'h00010);
        checkOutput("call_noret_fallthru", {14'd0, readAddr[rb + 45]}, 32'h00020);
        checkOutput("call_final_copr", {16'd0, COPR}, 32'h0008);

        // Skip: skip-next at 0x00, skip-assign at 0x20 to byte 0x80
        $display("[TB] skip");
        clearMem();
        writeTable(0, ctrlWord(3'b100, 4'h0), 16'h0300, 16'h8100);
        writeTable(1, ctrlWord(3'b101, 4'h0), 16'h0010, 16'h8200);
        writeTable(4, ctrlWord(3'b000, 4'h5), 16'h0000, 16'h8300);
        mem[5 * 16] = 16'h8000;
        rb = readAddr.size();
        ib = issuedCopr.size();
        rc = readCount;
        ic = issueCount;
        applyStimulus();
        waitEnd("skip_end_reached", 1000);
        checkOutput("skip_issues", issueCount - ic, 32'd1);
        checkOutput("skip_reads", readCount - rc, 32'd20);
        checkOutput("skip_issued_copr", {16'd0, issuedCopr[ib]}, 32'h0010);
        checkOutput("skip_next_addr", {14'd0, readAddr[rb + 2]}, 32'h00010);
        checkOutput("skip_assign_addr", {14'd0, readAddr[rb + 4]}, 32'h00040);
        checkOutput("skip_end_addr", {14'd0, readAddr[rb + 19]}, 32'h00050);

        // Random read latency and a slow draw engine
        $display("[TB] latency stress");
        loadLinear();
        randomDelay = 1'b1;
        ackDelay = 20;
        ib = issuedCopr.size();
        rc = readCount;
        ic = issueCount;
        vc = validCycles;
        n = unstable;
        applyStimulus();
        waitEnd("stress_end_reached", 5000);
        checkOutput("stress_issues", issueCount - ic, 32'd3);
        checkOutput("stress_reads", readCount - rc, 32'd46);
        checkOutput("stress_cmd_stable", unstable - n, 32'd0);
        checkOutput("stress_valid_cycles", validCycles - vc, 32'd63);
        checkOutput("stress_copr2", {16'd0, issuedCopr[ib + 2]}, 32'h0008);

        // START mid-body with a completion landing in the same cycle
        $display("[TB] abort");
        randomDelay = 1'b0;
        fixedDelay = 7;
        ackDelay = 0;
        applyStimulus();
        checkOutput("abort_cef_cleared", {31'd0, CEF}, 32'd0);
        n = 0;
        while (!(VRAM_RD === 1'b1 && VRAM_A === 18'h00006) && n < 500) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("abort_reached_word6", {14'd0, VRAM_A}, 32'h00006);
        respEnable = 1'b0;
        START = 1'b1;
        VRAM_DI = 16'hBEEF;
        VRAM_RDY = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        VRAM_RDY = 1'b0;
        checkOutput("abort_rd_low", {31'd0, VRAM_RD}, 32'd0);
        checkOutput("abort_busy", {31'd0, BUSY}, 32'd1);
        checkOutput("abort_copr", {16'd0, COPR}, 32'h0000);
        checkOutput("abort_cef", {31'd0, CEF}, 32'd0);
        checkOutput("abort_valid", {31'd0, CMD_VALID}, 32'd0);
        checkOutput("abort_word_discarded", {16'd0, CMD[111:96]}, 32'h3006);
        respEnable = 1'b1;
        n = 0;
        while (VRAM_RD !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("abort_restart_addr", {13'd0, VRAM_RD, VRAM_A}, 32'h40000);
        ic = issueCount;
        waitEnd("abort_end_reached", 3000);
        checkOutput("abort_issues", issueCount - ic, 32'd3);

        // START and CMD_ACK together: START wins, LOPR holds
        $display("[TB] start vs ack");
        ackEnable = 1'b0;
        fixedDelay = 0;
        applyStimulus();
        n = 0;
        while (CMD_VALID !== 1'b1 && n < 500) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("sva_valid_seen", {31'd0, CMD_VALID}, 32'd1);
        START = 1'b1;
        CMD_ACK = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        CMD_ACK = 1'b0;
        checkOutput("sva_valid_dropped", {31'd0, CMD_VALID}, 32'd0);
        checkOutput("sva_lopr_held", {16'd0, LOPR}, 32'h000C);
        checkOutput("sva_copr", {16'd0, COPR}, 32'h0000);

        // Reset overrides a simultaneous START
        @(negedge CLK);
        RST = 1'b1;
        START = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        START = 1'b0;
        checkOutput("rst_over_start_busy", {31'd0, BUSY}, 32'd0);
        checkOutput("rst_over_start_lopr", {16'd0, LOPR}, 32'd0);
        checkOutput("rst_over_start_rd", {31'd0, VRAM_RD}, 32'd0);
        ackEnable = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
